// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched micro-ops, snoops the CDB and issues one ready op
// per cycle. Define RS_AGE_ORDER_EN for oldest-first issue; otherwise lowest-index first.
module alu_reservation_station #(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             dispatch_valid,
  output logic             dispatch_ready,
  input  logic [3:0]       dispatch_op,
  input  logic             dispatch_src1_ready,
  input  logic [31:0]      dispatch_src1_value,
  input  logic [TAG_W-1:0] dispatch_src1_tag,
  input  logic             dispatch_src2_ready,
  input  logic [31:0]      dispatch_src2_value,
  input  logic [TAG_W-1:0] dispatch_src2_tag,
  input  logic [TAG_W-1:0] dispatch_dest_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [3:0]       issue_op,
  output logic [31:0]      issue_src1_data,
  output logic [31:0]      issue_src2_data,
  output logic [TAG_W-1:0] issue_dest_tag
);

  localparam int unsigned IdxW  = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam logic [3:0]  NoAlu = 4'd0;

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [NUM_ENTRIES-1:0] s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d;
  logic [3:0]             op_q     [NUM_ENTRIES];
  logic [3:0]             op_d     [NUM_ENTRIES];
  logic [31:0]            s1_val_q [NUM_ENTRIES];
  logic [31:0]            s1_val_d [NUM_ENTRIES];
  logic [31:0]            s2_val_q [NUM_ENTRIES];
  logic [31:0]            s2_val_d [NUM_ENTRIES];
  logic [TAG_W-1:0]       s1_tag_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       s1_tag_d [NUM_ENTRIES];
  logic [TAG_W-1:0]       s2_tag_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       s2_tag_d [NUM_ENTRIES];
  logic [TAG_W-1:0]       dest_q   [NUM_ENTRIES];
  logic [TAG_W-1:0]       dest_d   [NUM_ENTRIES];
`ifdef RS_AGE_ORDER_EN
  logic [IdxW-1:0]        rank_q   [NUM_ENTRIES];
  logic [IdxW-1:0]        rank_d   [NUM_ENTRIES];
`endif

  logic [NUM_ENTRIES-1:0] eligible;
  logic [IdxW-1:0]        sel_idx, free_idx;
  logic                   sel_found, free_found;
  logic                   issue_fire, dispatch_fire;
  logic                   byp1, byp2;

  always_comb begin
    eligible  = valid_q & s1_rdy_q & s2_rdy_q;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
`ifdef RS_AGE_ORDER_EN
      if (eligible[i] && (!sel_found || rank_q[i] < rank_q[sel_idx])) begin
`else
      if (eligible[i] && !sel_found) begin
`endif
        sel_found = 1'b1;
        sel_idx   = IdxW'(i);
      end
    end
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

  assign dispatch_ready = free_found;
  assign issue_valid    = sel_found;
  assign issue_fire     = sel_found & issue_ready & ~flush;
  assign dispatch_fire  = dispatch_valid & free_found & ~flush;
  assign byp1 = cdb_valid && !dispatch_src1_ready && (dispatch_src1_tag == cdb_tag);
  assign byp2 = cdb_valid && !dispatch_src2_ready && (dispatch_src2_tag == cdb_tag);

  always_comb begin
    issue_op        = NoAlu;
    issue_src1_data = '0;
    issue_src2_data = '0;
    issue_dest_tag  = '0;
    if (sel_found) begin
      issue_op        = op_q[sel_idx];
      issue_src1_data = s1_val_q[sel_idx];
      issue_src2_data = s2_val_q[sel_idx];
      issue_dest_tag  = dest_q[sel_idx];
    end
  end

  always_comb begin
`ifdef RS_AGE_ORDER_EN
    int unsigned cnt;
`endif
    valid_d  = valid_q;
    s1_rdy_d = s1_rdy_q;
    s2_rdy_d = s2_rdy_q;
    op_d     = op_q;
    s1_val_d = s1_val_q;
    s2_val_d = s2_val_q;
    s1_tag_d = s1_tag_q;
    s2_tag_d = s2_tag_q;
    dest_d   = dest_q;
`ifdef RS_AGE_ORDER_EN
    rank_d   = rank_q;
    cnt      = 0;
    for (int i = 0; i < NUM_ENTRIES; i++) cnt += 32'(valid_q[i]);
`endif
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (cdb_valid && valid_q[i] && !s1_rdy_q[i] && s1_tag_q[i] == cdb_tag) begin
        s1_rdy_d[i] = 1'b1;
        s1_val_d[i] = cdb_value;
      end
      if (cdb_valid && valid_q[i] && !s2_rdy_q[i] && s2_tag_q[i] == cdb_tag) begin
        s2_rdy_d[i] = 1'b1;
        s2_val_d[i] = cdb_value;
      end
    end
    if (issue_fire) begin
      valid_d[sel_idx] = 1'b0;
`ifdef RS_AGE_ORDER_EN
      // Entries younger than the leaving one close the gap in the rank order.
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (valid_q[i] && rank_q[i] > rank_q[sel_idx]) rank_d[i] = rank_q[i] - 1'b1;
      end
`endif
    end
    // The free slot is never the issued one, so this cannot collide with the clear above.
    if (dispatch_fire) begin
      valid_d[free_idx]  = 1'b1;
      op_d[free_idx]     = dispatch_op;
      s1_rdy_d[free_idx] = dispatch_src1_ready | byp1;
      s1_val_d[free_idx] = byp1 ? cdb_value : dispatch_src1_value;
      s1_tag_d[free_idx] = dispatch_src1_tag;
      s2_rdy_d[free_idx] = dispatch_src2_ready | byp2;
      s2_val_d[free_idx] = byp2 ? cdb_value : dispatch_src2_value;
      s2_tag_d[free_idx] = dispatch_src2_tag;
      dest_d[free_idx]   = dispatch_dest_tag;
`ifdef RS_AGE_ORDER_EN
      rank_d[free_idx]   = IdxW'(cnt - 32'(issue_fire));
`endif
    end
    if (flush) begin
      valid_d = '0;
`ifdef RS_AGE_ORDER_EN
      for (int i = 0; i < NUM_ENTRIES; i++) rank_d[i] = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      s1_rdy_q <= '0;
      s2_rdy_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        op_q[i]     <= NoAlu;
        s1_val_q[i] <= '0;
        s2_val_q[i] <= '0;
        s1_tag_q[i] <= '0;
        s2_tag_q[i] <= '0;
        dest_q[i]   <= '0;
`ifdef RS_AGE_ORDER_EN
        rank_q[i]   <= '0;
`endif
      end
    end else begin
      valid_q  <= valid_d;
      s1_rdy_q <= s1_rdy_d;
      s2_rdy_q <= s2_rdy_d;
      op_q     <= op_d;
      s1_val_q <= s1_val_d;
      s2_val_q <= s2_val_d;
      s1_tag_q <= s1_tag_d;
      s2_tag_q <= s2_tag_d;
      dest_q   <= dest_d;
`ifdef RS_AGE_ORDER_EN
      rank_q   <= rank_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios plus a randomized run against a
// slot-level reference model (oldest-first by dispatch sequence when RS_AGE_ORDER_EN is defined).
module tb_alu_reservation_station;

  localparam logic [3:0] NO_OP  = 4'd0;
  localparam logic [3:0] ADD_OP = 4'd1;
  localparam logic [3:0] SUB_OP = 4'd2;

  logic        clk = 1'b0;
  logic        rst, flush, dispatch_valid, dispatch_ready;
  logic [3:0]  dispatch_op;
  logic        dispatch_src1_ready, dispatch_src2_ready;
  logic [31:0] dispatch_src1_value, dispatch_src2_value;
  logic [3:0]  dispatch_src1_tag, dispatch_src2_tag, dispatch_dest_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        issue_valid, issue_ready;
  logic [3:0]  issue_op, issue_dest_tag;
  logic [31:0] issue_src1_data, issue_src2_data;

  int n_checks = 0;
  int n_fail   = 0;

  alu_reservation_station #(.NUM_ENTRIES(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_op(dispatch_op),
    .dispatch_src1_ready(dispatch_src1_ready), .dispatch_src1_value(dispatch_src1_value),
    .dispatch_src1_tag(dispatch_src1_tag),
    .dispatch_src2_ready(dispatch_src2_ready), .dispatch_src2_value(dispatch_src2_value),
    .dispatch_src2_tag(dispatch_src2_tag),
    .dispatch_dest_tag(dispatch_dest_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_src1_data(issue_src1_data), .issue_src2_data(issue_src2_data),
    .issue_dest_tag(issue_dest_tag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    flush = 1'b0; dispatch_valid = 1'b0; dispatch_op = NO_OP;
    dispatch_src1_ready = 1'b0; dispatch_src1_value = '0; dispatch_src1_tag = '0;
    dispatch_src2_ready = 1'b0; dispatch_src2_value = '0; dispatch_src2_tag = '0;
    dispatch_dest_tag = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    issue_ready = 1'b0;
  endtask

  task automatic disp(input logic [3:0] op, input logic r1, input logic [31:0] v1,
                      input logic [3:0] t1, input logic r2, input logic [31:0] v2,
                      input logic [3:0] t2, input logic [3:0] dest);
    dispatch_valid = 1'b1; dispatch_op = op;
    dispatch_src1_ready = r1; dispatch_src1_value = v1; dispatch_src1_tag = t1;
    dispatch_src2_ready = r2; dispatch_src2_value = v2; dispatch_src2_tag = t2;
    dispatch_dest_tag = dest;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_issue_valid: got %b want 0", issue_valid); end
    n_checks++; if (dispatch_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_dispatch_ready: got %b want 1", dispatch_ready); end
    n_checks++; if ({issue_op, issue_src1_data, issue_src2_data, issue_dest_tag} !== '0) begin
      n_fail++; $display("FAIL reset_idle_outputs: op %0d d1 %0h d2 %0h dest %0d want all 0",
                         issue_op, issue_src1_data, issue_src2_data, issue_dest_tag); end
  endtask

  task automatic test_basic_add();
    do_reset();
    disp(ADD_OP, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3);
    tick();
    dispatch_valid = 1'b0;
    n_checks++; if (issue_valid !== 1'b1 || issue_op !== ADD_OP) begin n_fail++;
      $display("FAIL add_issue: valid %b op %0d want 1/%0d", issue_valid, issue_op, ADD_OP); end
    n_checks++; if (issue_src1_data !== 32'd5 || issue_src2_data !== 32'd7) begin n_fail++;
      $display("FAIL add_data: got %0d/%0d want 5/7", issue_src1_data, issue_src2_data); end
    n_checks++; if (issue_dest_tag !== 4'd3) begin n_fail++;
      $display("FAIL add_dest: got %0d want 3", issue_dest_tag); end
    issue_ready = 1'b1;
    n_checks++; if (dispatch_ready !== 1'b1) begin n_fail++;
      $display("FAIL add_dispatch_ready: got %b want 1", dispatch_ready); end
    tick();
    issue_ready = 1'b0;
    n_checks++; if (issue_valid !== 1'b0 || dispatch_ready !== 1'b1) begin n_fail++;
      $display("FAIL add_freed: valid %b ready %b want 0/1", issue_valid, dispatch_ready); end
  endtask

  task automatic test_cdb_wakeup();
    do_reset();
    disp(SUB_OP, 1'b0, 32'd0, 4'd9, 1'b1, 32'd2, 4'd0, 4'd4);
    tick();
    dispatch_valid = 1'b0;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++;
      $display("FAIL wake_wait1: issue_valid %b want 0", issue_valid); end
    tick();
    cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_value = 32'd20;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++;
      $display("FAIL wake_same_cycle: issue_valid %b want 0", issue_valid); end
    tick();
    cdb_valid = 1'b0;
    n_checks++; if (issue_valid !== 1'b1 || issue_op !== SUB_OP) begin n_fail++;
      $display("FAIL wake_issue: valid %b op %0d want 1/%0d", issue_valid, issue_op, SUB_OP); end
    n_checks++; if (issue_src1_data !== 32'd20 || issue_src2_data !== 32'd2) begin n_fail++;
      $display("FAIL wake_data: got %0d/%0d want 20/2", issue_src1_data, issue_src2_data); end
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
  endtask

  task automatic test_bypass();
    do_reset();
    disp(ADD_OP, 1'b0, 32'd0, 4'd6, 1'b1, 32'd1, 4'd0, 4'd5);
    cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_value = 32'h55;
    tick();
    clear_inputs();
    n_checks++; if (issue_valid !== 1'b1 || issue_src1_data !== 32'h55) begin n_fail++;
      $display("FAIL bypass: valid %b src1 %0h want 1/55", issue_valid, issue_src1_data); end
  endtask

  task automatic test_full_and_stall();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      disp(ADD_OP, 1'b0, 32'd0, 4'd1, 1'b1, 32'(i), 4'd0, 4'(i + 1));
      tick();
    end
    disp(ADD_OP, 1'b1, 32'd9, 4'd0, 1'b1, 32'd9, 4'd0, 4'd15);
    n_checks++; if (dispatch_ready !== 1'b0 || issue_valid !== 1'b0) begin n_fail++;
      $display("FAIL full: ready %b valid %b want 0/0", dispatch_ready, issue_valid); end
    tick();
    dispatch_valid = 1'b0;
    n_checks++; if (dispatch_ready !== 1'b0 || issue_valid !== 1'b0) begin n_fail++;
      $display("FAIL full_held: ready %b valid %b want 0/0", dispatch_ready, issue_valid); end
    cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_value = 32'h100;
    tick();
    cdb_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (issue_valid !== 1'b1 || issue_dest_tag !== 4'd1 || issue_src1_data !== 32'h100) begin
        n_fail++; $display("FAIL stall_stable cycle %0d: valid %b dest %0d src1 %0h want 1/1/100",
                           c, issue_valid, issue_dest_tag, issue_src1_data); end
      tick();
    end
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (issue_valid !== 1'b1 || issue_dest_tag !== 4'(k + 1) ||
                      issue_src2_data !== 32'(k)) begin n_fail++;
        $display("FAIL drain %0d: valid %b dest %0d src2 %0d want 1/%0d/%0d",
                 k, issue_valid, issue_dest_tag, issue_src2_data, k + 1, k); end
      n_checks++; if (dispatch_ready !== (k > 0)) begin n_fail++;
        $display("FAIL drain_ready %0d: got %b want %b", k, dispatch_ready, k > 0); end
      tick();
    end
    issue_ready = 1'b0;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++;
      $display("FAIL drain_empty: issue_valid %b want 0", issue_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    disp(ADD_OP, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 4'd7);
    tick();
    disp(ADD_OP, 1'b1, 32'd2, 4'd0, 1'b1, 32'd2, 4'd0, 4'd8);
    tick();
    disp(SUB_OP, 1'b1, 32'd3, 4'd0, 1'b1, 32'd3, 4'd0, 4'd9);
    flush = 1'b1; issue_ready = 1'b1;
    tick();
    clear_inputs();
    n_checks++; if (issue_valid !== 1'b0 || dispatch_ready !== 1'b1) begin n_fail++;
      $display("FAIL flush: valid %b ready %b want 0/1", issue_valid, dispatch_ready); end
    tick();
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++;
      $display("FAIL flush_retained: issue_valid %b dest %0d want 0", issue_valid,
               issue_dest_tag); end
  endtask

  task automatic test_order_basic();
    do_reset();
    disp(ADD_OP, 1'b0, 32'd0, 4'd5, 1'b1, 32'd0, 4'd0, 4'd10);
    tick();
    disp(ADD_OP, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 4'd11);
    tick();
    disp(ADD_OP, 1'b1, 32'd2, 4'd0, 1'b1, 32'd2, 4'd0, 4'd12);
    tick();
    dispatch_valid = 1'b0;
    n_checks++; if (issue_dest_tag !== 4'd11) begin n_fail++;
      $display("FAIL order_first: dest %0d want 11", issue_dest_tag); end
    issue_ready = 1'b1; cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_value = 32'h33;
    tick();
    cdb_valid = 1'b0;
    n_checks++; if (issue_dest_tag !== 4'd10 || issue_src1_data !== 32'h33) begin n_fail++;
      $display("FAIL order_second: dest %0d src1 %0h want 10/33", issue_dest_tag,
               issue_src1_data); end
    tick();
    n_checks++; if (issue_dest_tag !== 4'd12) begin n_fail++;
      $display("FAIL order_third: dest %0d want 12", issue_dest_tag); end
    tick();
    issue_ready = 1'b0;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++;
      $display("FAIL order_empty: issue_valid %b want 0", issue_valid); end
  endtask

  // Younger Z refills entry 0 below older Y in entry 1; the policy decides who goes first.
  task automatic test_order_age();
    logic [3:0] first, second;
`ifdef RS_AGE_ORDER_EN
    first = 4'd2; second = 4'd3;
`else
    first = 4'd3; second = 4'd2;
`endif
    do_reset();
    disp(ADD_OP, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 4'd1);
    tick();
    disp(ADD_OP, 1'b0, 32'd0, 4'd7, 1'b1, 32'd2, 4'd0, 4'd2);
    tick();
    dispatch_valid = 1'b0; issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    disp(SUB_OP, 1'b1, 32'd3, 4'd0, 1'b1, 32'd3, 4'd0, 4'd3);
    tick();
    dispatch_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_value = 32'h77;
    tick();
    cdb_valid = 1'b0;
    n_checks++; if (issue_dest_tag !== first) begin n_fail++;
      $display("FAIL age_first: dest %0d want %0d", issue_dest_tag, first); end
    issue_ready = 1'b1;
    tick();
    n_checks++; if (issue_dest_tag !== second) begin n_fail++;
      $display("FAIL age_second: dest %0d want %0d", issue_dest_tag, second); end
    tick();
    issue_ready = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic        r1;
    logic [31:0] v1;
    logic [3:0]  t1;
    logic        r2;
    logic [31:0] v2;
    logic [3:0]  t2;
    logic [3:0]  dest;
    int unsigned seq;
  } slot_t;

  task automatic test_random();
    slot_t       m [4];
    int unsigned seq_ctr = 0;
    int          sel, free;
    logic        exp_ready;
    do_reset();
    for (int i = 0; i < 4; i++) m[i].v = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      sel = -1; free = -1;
      for (int i = 0; i < 4; i++) begin
        if (m[i].v && m[i].r1 && m[i].r2) begin
`ifdef RS_AGE_ORDER_EN
          if (sel < 0 || m[i].seq < m[sel].seq) sel = i;
`else
          if (sel < 0) sel = i;
`endif
        end
        if (!m[i].v && free < 0) free = i;
      end
      exp_ready = (free >= 0);
      n_checks++; if (dispatch_ready !== exp_ready || issue_valid !== (sel >= 0)) begin
        n_fail++; $display("FAIL rand_hs cyc %0d: ready %b valid %b want %b/%b", cyc,
                           dispatch_ready, issue_valid, exp_ready, sel >= 0); end
      if (sel >= 0) begin
        n_checks++; if (issue_op !== m[sel].op || issue_src1_data !== m[sel].v1 ||
                        issue_src2_data !== m[sel].v2 || issue_dest_tag !== m[sel].dest) begin
          n_fail++; $display("FAIL rand_issue cyc %0d: %0d %0h %0h %0d want %0d %0h %0h %0d",
            cyc, issue_op, issue_src1_data, issue_src2_data, issue_dest_tag,
            m[sel].op, m[sel].v1, m[sel].v2, m[sel].dest); end
      end else begin
        n_checks++; if ({issue_op, issue_src1_data, issue_src2_data, issue_dest_tag} !== '0)
        begin n_fail++; $display("FAIL rand_idle cyc %0d: outputs not zero", cyc); end
      end
      flush               = ($urandom_range(0, 24) == 0);
      dispatch_valid      = $urandom_range(0, 1);
      dispatch_op         = 4'($urandom_range(1, 15));
      dispatch_src1_ready = $urandom_range(0, 1);
      dispatch_src1_value = $urandom;
      dispatch_src1_tag   = 4'($urandom_range(0, 3));
      dispatch_src2_ready = $urandom_range(0, 1);
      dispatch_src2_value = $urandom;
      dispatch_src2_tag   = 4'($urandom_range(0, 3));
      dispatch_dest_tag   = 4'($urandom);
      cdb_valid           = $urandom_range(0, 1);
      cdb_tag             = 4'($urandom_range(0, 3));
      cdb_value           = $urandom;
      issue_ready         = $urandom_range(0, 1);
      if (flush) begin
        for (int i = 0; i < 4; i++) m[i].v = 1'b0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (cdb_valid && m[i].v && !m[i].r1 && m[i].t1 == cdb_tag) begin
            m[i].r1 = 1'b1; m[i].v1 = cdb_value;
          end
          if (cdb_valid && m[i].v && !m[i].r2 && m[i].t2 == cdb_tag) begin
            m[i].r2 = 1'b1; m[i].v2 = cdb_value;
          end
        end
        if (sel >= 0 && issue_ready) m[sel].v = 1'b0;
        if (dispatch_valid && free >= 0) begin
          m[free].v = 1'b1; m[free].op = dispatch_op; m[free].dest = dispatch_dest_tag;
          m[free].t1 = dispatch_src1_tag; m[free].t2 = dispatch_src2_tag;
          m[free].r1 = dispatch_src1_ready || (cdb_valid && dispatch_src1_tag == cdb_tag);
          m[free].v1 = dispatch_src1_ready ? dispatch_src1_value :
                       (cdb_valid && dispatch_src1_tag == cdb_tag) ? cdb_value
                                                                   : dispatch_src1_value;
          m[free].r2 = dispatch_src2_ready || (cdb_valid && dispatch_src2_tag == cdb_tag);
          m[free].v2 = dispatch_src2_ready ? dispatch_src2_value :
                       (cdb_valid && dispatch_src2_tag == cdb_tag) ? cdb_value
                                                                   : dispatch_src2_value;
          m[free].seq = seq_ctr;
          seq_ctr++;
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_basic_add();
    test_cdb_wakeup();
    test_bypass();
    test_full_and_stall();
    test_flush();
    test_order_basic();
    test_order_age();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
